// File: rtl/lod_arbiter.sv
// Leading-one-detect round-robin arbiter: the highest-index requester below the
// last winner is granted next, with a per-grant hold limit that forces release.
module lod_arbiter #(
    parameter int N        = 16,
    parameter int MAX_HOLD = 255,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic          timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [7:0]    hold_q, hold_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  masked_req;
    logic [N-1:0]  cand;
    logic [N-1:0]  win_onehot;
    logic [N-1:0]  win_lower;
    logic [IW-1:0] win_idx;
    logic          win_any;

    // Fall back to the raw request vector when nothing below the pointer asks.
    always_comb begin
        masked_req = req & mask_q;
        cand       = (|masked_req) ? masked_req : req;
        win_any    = |req;
        win_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // A winner at index 0 wraps the pointer back to all requesters.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_win
            assign win_onehot[gi] = win_any && (win_idx == IW'(gi));
            assign win_lower[gi]  = (win_idx == '0) || (IW'(gi) < win_idx);
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        hold_d    = hold_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = 8'd0;
                if (win_any) begin
                    state_d = GRANT;
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                    mask_d  = win_lower;
                    hold_d  = 8'd1;
                end
            end
            GRANT: begin
                if (done || !req[idx_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    hold_d  = 8'd0;
                end else if (hold_q == 8'(MAX_HOLD)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    idx_d     = '0;
                    valid_d   = 1'b0;
                    hold_d    = 8'd0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
                valid_d = 1'b0;
                hold_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '1;
            hold_q    <= 8'd0;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            hold_q    <= hold_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_idx   = idx_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_lod_arbiter.sv
// Bench for lod_arbiter (N=16, MAX_HOLD=4): directed scenarios plus a randomized
// run checked against a pointer-based round-robin model.
module tb_lod_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 4;
    localparam int IW       = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          timeout;

    int errors;
    int checks;

    // Model: granted index (-1 when idle), hold count, and a pointer meaning
    // "only indices below m_ptr are preferred" (m_ptr == N prefers everyone).
    int m_gnt;
    int m_hold;
    int m_ptr;
    bit m_to;

    lod_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IW(IW)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant(grant), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input logic [N-1:0] r, input logic d, input logic s);
        int pick;
        if (s) begin
            m_gnt = -1; m_hold = 0; m_ptr = N; m_to = 0;
        end else if (m_gnt < 0) begin
            pick = -1;
            for (int i = 0; i < m_ptr; i++) if (r[i]) pick = i;
            if (pick < 0) for (int i = 0; i < N; i++) if (r[i]) pick = i;
            m_to = 0;
            if (pick >= 0) begin
                m_gnt  = pick;
                m_hold = 1;
                m_ptr  = (pick == 0) ? N : pick;
            end
        end else if (d || !r[m_gnt]) begin
            m_gnt = -1; m_hold = 0; m_to = 0;
        end else if (m_hold == MAX_HOLD) begin
            m_gnt = -1; m_hold = 0; m_to = 1;
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    // Apply inputs for one cycle, advance the model at the edge, return at negedge.
    task automatic drive(input logic [N-1:0] r, input logic d, input logic s);
        req = r; done = d; rst = s;
        @(posedge clk);
        model_step(r, d, s);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(16'hFFFF, 1'b0, 1'b1);
            checks++;
            if (grant !== 16'h0000 || grant_valid !== 1'b0 || grant_idx !== 4'd0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset c=%0d: got grant=%h valid=%b idx=%0d to=%b, need 0000/0/0/0",
                         c, grant, grant_valid, grant_idx, timeout);
            end
        end
    endtask

    task automatic test_single();
        logic [N-1:0] exp_g [3] = '{16'h0020, 16'h0020, 16'h0000};
        logic         dn    [3] = '{1'b0, 1'b0, 1'b1};
        drive(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(16'h0020, dn[c], 1'b0);
            checks++;
            if (grant !== exp_g[c] || grant_valid !== (exp_g[c] != 0) ||
                grant_idx !== ((exp_g[c] != 0) ? 4'd5 : 4'd0)) begin
                errors++;
                $display("FAIL single c=%0d: got grant=%h valid=%b idx=%0d, need grant=%h",
                         c, grant, grant_valid, grant_idx, exp_g[c]);
            end
        end
        drive(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g [5] = '{16'h8000, 16'h0000, 16'h0001, 16'h0000, 16'h8000};
        drive(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            drive(16'h8001, 1'b1, 1'b0);
            checks++;
            if (grant !== exp_g[c] || timeout !== 1'b0) begin
                errors++;
                $display("FAIL round_robin c=%0d: got grant=%h to=%b, need grant=%h to=0",
                         c, grant, timeout, exp_g[c]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp_g [6] = '{16'h0008, 16'h0008, 16'h0008, 16'h0008, 16'h0000, 16'h0008};
        logic         exp_t [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drive(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) begin
            drive(16'h0008, 1'b0, 1'b0);
            checks++;
            if (grant !== exp_g[c] || timeout !== exp_t[c]) begin
                errors++;
                $display("FAIL timeout c=%0d: got grant=%h to=%b, need grant=%h to=%b",
                         c, grant, timeout, exp_g[c], exp_t[c]);
            end
        end
    endtask

    task automatic test_release_priority();
        drive(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) drive(16'h0400, 1'b0, 1'b0);
        checks++;
        if (grant !== 16'h0400 || grant_idx !== 4'd10) begin
            errors++;
            $display("FAIL release_prio_hold: got grant=%h idx=%0d, need 0400/10", grant, grant_idx);
        end
        drive(16'h0000, 1'b0, 1'b0);
        checks++;
        if (grant !== 16'h0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL release_prio: got grant=%h to=%b, need 0000/0", grant, timeout);
        end
    endtask

    task automatic test_reset_mid_grant();
        drive(16'h0000, 1'b0, 1'b1);
        drive(16'h0101, 1'b0, 1'b0);
        checks++;
        if (grant !== 16'h0100) begin
            errors++;
            $display("FAIL rst_mid_first: got grant=%h, need 0100", grant);
        end
        drive(16'h0101, 1'b0, 1'b1);
        checks++;
        if (grant !== 16'h0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_abort: got grant=%h valid=%b to=%b, need 0000/0/0",
                     grant, grant_valid, timeout);
        end
        drive(16'h0101, 1'b0, 1'b0);
        checks++;
        if (grant !== 16'h0100 || grant_idx !== 4'd8 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_regrant: got grant=%h idx=%0d to=%b, need 0100/8/0",
                     grant, grant_idx, timeout);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic [N-1:0] exp_g;
        drive(16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            r = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = 16'(1) << $urandom_range(0, N - 1);
            drive(r, ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0));
            exp_g = (m_gnt < 0) ? 16'h0000 : (16'(1) << m_gnt);
            checks++;
            if (grant !== exp_g || grant_valid !== (m_gnt >= 0) ||
                grant_idx !== ((m_gnt < 0) ? 4'd0 : 4'(m_gnt)) || timeout !== m_to) begin
                errors++;
                $display("FAIL random c=%0d: got grant=%h valid=%b idx=%0d to=%b, need grant=%h to=%b",
                         c, grant, grant_valid, grant_idx, timeout, exp_g, m_to);
            end
            checks++;
            if (!$onehot0(grant)) begin
                errors++;
                $display("FAIL onehot c=%0d: got grant=%h, need at most one bit", c, grant);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_gnt = -1; m_hold = 0; m_ptr = N; m_to = 0;
        req = '0; done = 1'b0; rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_release_priority();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
